// File: rtl/pipe_ctrl_if.sv
// Pipeline/controller signal bundle: hazard and multi-cycle requests in, stall/divider control out.
// master = pipeline side driving requests, slave = pipe_ctrl.
interface pipe_ctrl_if #(
   parameter int PERF_W = 32
);
   logic              stallreq_id;
   logic              ex_madd;
   logic              ex_div;
   logic              ex_div_signed;
   logic              div_ready;
   logic [5:0]        stall;
   logic [1:0]        ex_cnt;
   logic              div_start;
   logic              div_signed;
   logic              div_timeout;
   logic [PERF_W-1:0] stall_cycles;

   modport master (
      output stallreq_id, ex_madd, ex_div, ex_div_signed, div_ready,
      input  stall, ex_cnt, div_start, div_signed, div_timeout, stall_cycles
   );

   modport slave (
      input  stallreq_id, ex_madd, ex_div, ex_div_signed, div_ready,
      output stall, ex_cnt, div_start, div_signed, div_timeout, stall_cycles
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall sequencer for the 5-stage core: MADD two-phase, divider handshake with timeout, stall counter.
// stall/ex_cnt/div_start/div_signed are combinational (0-cycle); no backpressure, div_ready is a 1-cycle pulse.
module pipe_ctrl #(
   parameter int DIV_TIMEOUT = 40,
   parameter int PERF_W      = 32
) (
   input  logic       clk,
   input  logic       rst,
   pipe_ctrl_if.slave bus
);
   localparam int            CW       = $clog2(DIV_TIMEOUT) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, MADD2, DIV_BUSY} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              sgn_q, sgn_d;
   logic              tmo_q, tmo_d;
   logic [PERF_W-1:0] perf_q;

   logic              ex_req;
   logic [1:0]        ex_cnt_c;
   logic              start_c;
   logic              signed_c;
   logic [5:0]        stall_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sgn_q   <= 1'b0;
         tmo_q   <= 1'b0;
         perf_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sgn_q   <= sgn_d;
         tmo_q   <= tmo_d;
         if (stall_c != 6'd0 && perf_q != {PERF_W{1'b1}})
            perf_q <= perf_q + 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sgn_d    = sgn_q;
      tmo_d    = tmo_q;
      ex_req   = 1'b0;
      ex_cnt_c = 2'd0;
      start_c  = 1'b0;
      signed_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.ex_madd) begin
               ex_req  = 1'b1;
               state_d = MADD2;
            end else if (bus.ex_div) begin
               ex_req   = 1'b1;
               start_c  = 1'b1;
               signed_c = bus.ex_div_signed;
               sgn_d    = bus.ex_div_signed;
               cnt_d    = '0;
               state_d  = DIV_BUSY;
            end
         end
         MADD2: begin
            ex_cnt_c = 2'd1;
            state_d  = IDLE;
         end
         DIV_BUSY: begin
            // Release on the ready pulse, or force it once the stall budget is spent.
            if (bus.div_ready) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               tmo_d   = 1'b1;
               state_d = IDLE;
            end else begin
               ex_req   = 1'b1;
               start_c  = 1'b1;
               signed_c = sgn_q;
               cnt_d    = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // EX stall already covers PC/IF/ID, so it overrides the ID request.
   assign stall_c = ex_req          ? 6'b001111 :
                    bus.stallreq_id ? 6'b000111 : 6'b000000;

   // Reset silences every output immediately, including an in-flight divide.
   assign bus.stall        = rst ? 6'd0       : stall_c;
   assign bus.ex_cnt       = rst ? 2'd0       : ex_cnt_c;
   assign bus.div_start    = rst ? 1'b0       : start_c;
   assign bus.div_signed   = rst ? 1'b0       : signed_c;
   assign bus.div_timeout  = rst ? 1'b0       : tmo_q;
   assign bus.stall_cycles = rst ? {PERF_W{1'b0}} : perf_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized scoreboard bench for pipe_ctrl against a cycle-budget reference model.
`timescale 1ns/1ps
module tb_pipe_ctrl;
   localparam int PERF_W = 8;
   localparam int T      = 40;
   localparam int PMAX   = (1 << PERF_W) - 1;

   typedef struct {
      logic [5:0]        stall;
      logic [1:0]        ex_cnt;
      logic              div_start;
      logic              div_signed;
      logic              div_timeout;
      logic [PERF_W-1:0] perf;
   } exp_t;

   logic clk;
   logic rst;
   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: a MADD owes one follow-up cycle; a divide owns a budget of T stalled cycles.
   bit m_madd_pending = 0;
   int m_used         = 0;
   bit m_sgn          = 0;
   bit m_tmo          = 0;
   int m_perf         = 0;
   bit cur_sg         = 0;

   pipe_ctrl_if #(.PERF_W(PERF_W)) bus ();

   pipe_ctrl #(.DIV_TIMEOUT(T), .PERF_W(PERF_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic step(input bit r, input bit sid, input bit md, input bit dv,
                       input bit sg, input bit rdy);
      exp_t e;
      bit   exs;
      @(posedge clk);
      #1;
      rst               = r;
      bus.stallreq_id   = sid;
      bus.ex_madd       = md;
      bus.ex_div        = dv;
      bus.ex_div_signed = sg;
      bus.div_ready     = rdy;
      e.stall = 6'd0; e.ex_cnt = 2'd0; e.div_start = 1'b0;
      e.div_signed = 1'b0; e.div_timeout = 1'b0; e.perf = '0;
      if (r) begin
         m_madd_pending = 0; m_used = 0; m_tmo = 0; m_perf = 0;
         q.push_back(e);
         return;
      end
      e.div_timeout = m_tmo;
      e.perf        = PERF_W'(m_perf);
      exs           = 0;
      if (m_madd_pending) begin
         e.ex_cnt       = 2'd1;
         m_madd_pending = 0;
      end else if (m_used > 0) begin
         if (rdy) begin
            m_used = 0;
         end else if (m_used == T) begin
            m_used = 0;
            m_tmo  = 1;
         end else begin
            exs          = 1;
            e.div_start  = 1'b1;
            e.div_signed = m_sgn;
            m_used++;
         end
      end else if (md) begin
         exs            = 1;
         m_madd_pending = 1;
      end else if (dv) begin
         exs          = 1;
         e.div_start  = 1'b1;
         e.div_signed = sg;
         m_sgn        = sg;
         m_used       = 1;
      end
      e.stall = exs ? 6'b001111 : (sid ? 6'b000111 : 6'b000000);
      if (e.stall != 6'd0 && m_perf < PMAX) m_perf++;
      q.push_back(e);
   endtask

   // Monitor: the DUT presents a full output set every cycle; check it mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("stall",        32'(bus.stall),        32'(e.stall));
            chk("ex_cnt",       32'(bus.ex_cnt),       32'(e.ex_cnt));
            chk("div_start",    32'(bus.div_start),    32'(e.div_start));
            if (e.div_start)
               chk("div_signed", 32'(bus.div_signed),  32'(e.div_signed));
            chk("div_timeout",  32'(bus.div_timeout),  32'(e.div_timeout));
            chk("stall_cycles", 32'(bus.stall_cycles), 32'(e.perf));
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit sg;
      rst = 1'b1;
      bus.stallreq_id = 1'b0; bus.ex_madd = 1'b0; bus.ex_div = 1'b0;
      bus.ex_div_signed = 1'b0; bus.div_ready = 1'b0;

      // Reset with a divide requested, then ID hazard, then MADD.
      step(1, 0, 0, 1, 1, 0);
      step(1, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Signed divide with ready 34 cycles after entry; ID request during the stall.
      for (int i = 0; i < 34; i++) step(0, (i == 10), 0, 1, 1, 0);
      step(0, 0, 0, 1, 1, 1);
      step(0, 0, 0, 0, 0, 0);

      // Divide that never completes.
      for (int i = 0; i < 45; i++) step(0, 0, 0, (i == 0), 0, 0);

      // Back-to-back MADD right after a divide release.
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Reset mid-divide, then a fresh divide runs its full budget.
      step(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 0, 0);
      for (int i = 0; i < 45; i++) step(0, 0, 0, (i == 0), 1, 0);

      for (int i = 0; i < 4000; i++) begin
         if (m_used == 0) cur_sg = 1'($urandom);
         sg = cur_sg;
         step(($urandom_range(0, 799) == 0),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 7) == 0),
              sg,
              ($urandom_range(0, 24) == 0));
      end

      @(posedge clk);
      @(negedge clk);
      #1;
      chk("queue_drain", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It produces the 6-bit `stall` vector that freezes PC/IF/ID/EX/MEM/WB and inserts bubbles through the pipeline registers. It sequences multi-cycle EX operations: two-cycle MADD/MSUB accumulation and the handshake with the iterative divider, including a timeout guard. It sits beside the pipeline and also keeps a saturating stall-cycle performance counter.

## Interface

Parameters:
- `DIV_TIMEOUT`, default 40: maximum number of cycles spent in DIV_BUSY before a forced release.
- `PERF_W`, default 32: width of the stall-cycle counter.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `stallreq_id`  in  1  ID-stage hazard stall request, e.g. load-use.
- `ex_madd`  in  1  EX holds a MADD/MADDU/MSUB/MSUBU instruction.
- `ex_div`  in  1  EX holds a DIV/DIVU instruction.
- `ex_div_signed`  in  1  the EX divide is signed (DIV).
- `div_ready`  in  1  divider result valid; pulses for 1 cycle.
- `stall`  out  6  per-stage stall; bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop.
- `ex_cnt`  out  2  MADD phase to EX: 0 = first cycle, 1 = second cycle.
- `div_start`  out  1  divider start/hold; level signal.
- `div_signed`  out  1  signed-mode to divider; valid while `div_start`=1.
- `div_timeout`  out  1  sticky error flag; set on divider timeout.
- `stall_cycles`  out  PERF_W  count of cycles with `stall`≠0; saturates at all-ones.

## Operation

State machine states: IDLE, MADD2, DIV_BUSY.

Stall encodings:
- EX request: 6'b001111.
- ID request only: 6'b000111.
- none: 6'b000000.
- An EX request always dominates an ID request.

Outputs `stall`, `ex_cnt`, `div_start` and `div_signed` are combinational from state and inputs.

IDLE:
- `ex_madd`=1: `stall`=001111, `ex_cnt`=0, next state MADD2.
- else if `ex_div`=1: `div_start`=1, `div_signed`=`ex_div_signed`, `stall`=001111, clear the timeout counter, next state DIV_BUSY.
- else: `stall` follows `stallreq_id`; stay in IDLE.
- `div_ready` is ignored in IDLE.

MADD2:
- `ex_cnt`=1, no EX stall; `stall` follows `stallreq_id`.
- Next state IDLE unconditionally. `ex_madd` is not re-evaluated in this cycle.

DIV_BUSY:
- `div_ready`=0 and the counter is below DIV_TIMEOUT−1: `div_start`=1, `stall`=001111, increment the counter.
- `div_ready`=1: `div_start`=0, EX stall released (`stall` follows `stallreq_id`), next state IDLE. The EX instruction advances at this edge carrying the divider result.
- counter = DIV_TIMEOUT−1 and `div_ready`=0: same release as on `div_ready`, and set `div_timeout`.

`div_timeout` is sticky and cleared only by `rst`.

`stall_cycles` increments on each clock edge where `stall`≠0, and holds once it reaches 2^PERF_W−1.

Reset:
- All outputs are forced 0 while `rst`=1, regardless of state.
- Registered state returns to IDLE; counters and `div_timeout` clear.
- `rst` during DIV_BUSY drops `div_start` in the same cycle and abandons the divide.

## Timing

- Latency from request to `stall` is 0 cycles, because `stall` is combinational.
- MADD: exactly 2 EX cycles. In cycle A, `stall`=001111 and `ex_cnt`=0. In cycle B, `ex_cnt`=1 with no EX stall.
- DIV: `div_start` rises in the same cycle `ex_div` is first seen in IDLE. It stays high every cycle up to, but not including, the `div_ready` cycle.
- The `div_ready` cycle has `stall[3]`=0.
- The EX stall lasts at most DIV_TIMEOUT cycles in total, including the entry cycle.
- Back-to-back: if a new MADD/DIV enters EX the cycle after release, it is accepted from IDLE the next cycle with no extra bubble.
- `stallreq_id` asserted during an EX stall produces no change, because 001111 already covers it.

## Test plan

- Reset: hold `rst` 2 cycles with `ex_div`=1 -> `stall`=0, `div_start`=0, `stall_cycles`=0, `div_timeout`=0.
- ID hazard: `stallreq_id`=1 for 1 cycle in IDLE -> `stall`=000111 for that cycle, then 000000; `stall_cycles`=1.
- MADD: `ex_madd`=1 for 2 cycles -> `stall`=001111 with `ex_cnt`=0, then `stall`=000000 with `ex_cnt`=1; `stall_cycles`=1.
- DIV with `ex_div_signed`=1 and `div_ready` pulsed 34 cycles after entry -> `div_start`=1 and `div_signed`=1 for 34 cycles, `stall`=001111 for 34 cycles, and `stall[3]`=0 in the ready cycle.
- Timeout: DIV_TIMEOUT=40 with `div_ready` never asserted -> `stall` released after 40 stall cycles; `div_timeout` goes to 1 and stays there until `rst`.
- Reset mid-divide: `rst` asserted 5 cycles into DIV_BUSY -> `div_start`=0 the same cycle, state IDLE; the next `ex_div` restarts with a fresh counter.
